// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage pipelined RV32I/Zicsr immediate generator.
// S1 decodes the format from the opcode; S2 builds the XLEN-wide immediate.
// A single valid/ready chain back-propagates stalls (no skid buffer), so
// in_ready is combinationally dependent on out_ready.
// Optional build macro IMMGEN_ILLEGAL_EN adds out_illegal, which flags words
// whose opcode is outside the decode table or whose low bits are not 2'b11.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
`ifdef IMMGEN_ILLEGAL_EN
    output logic             out_illegal,
`endif
    output logic [CNT_W-1:0] accept_cnt
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_CSR = 3'd6;

    logic             s1_valid_q;
    logic [2:0]       s1_fmt_q;
    logic [31:7]      s1_inst_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_valid_q;
    logic [XLEN-1:0]  out_imm_q;
    logic [2:0]       out_fmt_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [CNT_W-1:0] cnt_q;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_fire;
    logic [2:0]       fmt_d;
    logic [31:0]      imm32_d;
    logic [XLEN-1:0]  imm_d;

    // A stage may advance when it is empty or the stage after it advances
    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;
    assign in_fire  = in_valid && s1_adv;

    // Opcode -> format code; unknown opcodes fall through as R (imm = 0)
    always_comb begin
        fmt_d = FMT_R;
        case (in_inst[6:0])
            7'b0110011:                         fmt_d = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111: fmt_d = FMT_I;
            7'b0001111:                         fmt_d = FMT_I;
            7'b0100011:                         fmt_d = FMT_S;
            7'b1100011:                         fmt_d = FMT_B;
            7'b0110111, 7'b0010111:             fmt_d = FMT_U;
            7'b1101111:                         fmt_d = FMT_J;
            7'b1110011: fmt_d = (in_inst[14:12] != 3'd0) ? FMT_CSR : FMT_I;
            default:                            fmt_d = FMT_R;
        endcase
    end

    // S1 register: capture format, upper instruction bits and tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_fmt_q   <= FMT_R;
            s1_inst_q  <= '0;
            s1_tag_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_fmt_q  <= fmt_d;
                s1_inst_q <= in_inst[31:7];
                s1_tag_q  <= in_tag;
            end
        end
    end

    // Immediate assembly from the registered fields; the 32-bit result is
    // sign-extended to XLEN (CSR zimm is positive, so that also zero-extends)
    always_comb begin
        imm32_d = '0;
        case (s1_fmt_q)
            FMT_I:   imm32_d = {{20{s1_inst_q[31]}}, s1_inst_q[31:20]};
            FMT_S:   imm32_d = {{20{s1_inst_q[31]}}, s1_inst_q[31:25], s1_inst_q[11:7]};
            FMT_B:   imm32_d = {{19{s1_inst_q[31]}}, s1_inst_q[31], s1_inst_q[7],
                                s1_inst_q[30:25], s1_inst_q[11:8], 1'b0};
            FMT_U:   imm32_d = {s1_inst_q[31:12], 12'b0};
            FMT_J:   imm32_d = {{11{s1_inst_q[31]}}, s1_inst_q[31], s1_inst_q[19:12],
                                s1_inst_q[20], s1_inst_q[30:21], 1'b0};
            FMT_CSR: imm32_d = {27'b0, s1_inst_q[19:15]};
            default: imm32_d = '0;
        endcase
        imm_d = XLEN'($signed(imm32_d));
    end

    // S2 / output register: holds its word until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            out_imm_q  <= '0;
            out_fmt_q  <= FMT_R;
            out_tag_q  <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_imm_q <= imm_d;
                out_fmt_q <= s1_fmt_q;
                out_tag_q <= s1_tag_q;
            end
        end
    end

    // Count accepted input words; wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (in_fire) cnt_q <= cnt_q + CNT_W'(1);
    end

`ifdef IMMGEN_ILLEGAL_EN
    logic ill_d;
    logic s1_ill_q;
    logic out_ill_q;

    // Flag anything outside the decode table or not a 32-bit encoding
    always_comb begin
        ill_d = 1'b0;
        case (in_inst[6:0])
            7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111,
            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
            7'b1110011: ill_d = 1'b0;
            default:    ill_d = 1'b1;
        endcase
        if (in_inst[1:0] != 2'b11) ill_d = 1'b1;
    end

    // Illegal flag travels with the format through both stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ill_q  <= 1'b0;
            out_ill_q <= 1'b0;
        end else begin
            if (in_fire) s1_ill_q <= ill_d;
            if (s2_adv && s1_valid_q) out_ill_q <= s1_ill_q;
        end
    end

    assign out_illegal = out_ill_q;
`endif

    assign out_valid  = s2_valid_q;
    assign out_imm    = out_imm_q;
    assign out_fmt    = out_fmt_q;
    assign out_tag    = out_tag_q;
    assign accept_cnt = cnt_q;

endmodule
